// File: rtl/level_display.sv
// Four-digit multiplexed level display: snapshots a signed BCD level at a fixed
// hold rate and scans it onto a common-anode 7-segment display with blanking
// gaps between digits to suppress ghosting.
module level_display #(
  parameter int unsigned SCAN_CYCLES  = 12500,
  parameter int unsigned BLANK_CYCLES = 250,
  parameter int unsigned HOLD_CYCLES  = 6000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] num2,
  input  logic [3:0] num1,
  input  logic [3:0] num0,
  input  logic       neg,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  // One slot counter serves both states, so it is sized for the longer one.
  localparam int unsigned SlotMax = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int unsigned SlotW   = $clog2(SlotMax);
  localparam int unsigned HoldW   = $clog2(HOLD_CYCLES);

  localparam logic [SlotW-1:0] ScanLast  = SlotW'(SCAN_CYCLES - 1);
  localparam logic [SlotW-1:0] BlankLast = SlotW'(BLANK_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast  = HoldW'(HOLD_CYCLES - 1);

  localparam logic [6:0] SegOff   = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;

  typedef enum logic [0:0] {StScan, StBlank} state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [HoldW-1:0] hold_q, hold_d;
  // Snapshot layout: {neg, num2, num1, num0}.
  logic [12:0]      pend_val_q, snap_q, snap_d;
  logic             pend_flag_q;
  logic             hold_wrap, transfer;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show 'E'.
  function automatic logic [6:0] encode(input logic [3:0] v);
    case (v)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = 7'b0000110;
    endcase
  endfunction

  // Scan/blank sequencing and hold-interval timing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = SlotW'(slot_q + 1'b1);
    unique case (state_q)
      StScan: begin
        if (slot_q == ScanLast) begin
          state_d = StBlank;
          slot_d  = '0;
        end
      end
      StBlank: begin
        if (slot_q == BlankLast) begin
          state_d = StScan;
          idx_d   = idx_q + 2'd1;
          slot_d  = '0;
        end
      end
      default: begin
        state_d = StBlank;
        slot_d  = '0;
      end
    endcase

    hold_wrap = (hold_q == HoldLast);
    hold_d    = hold_wrap ? '0 : HoldW'(hold_q + 1'b1);

    // New values only appear at the start of a frame so a frame is never torn.
    transfer = (state_q == StBlank) && (state_d == StScan) && (idx_d == 2'd0);
    snap_d   = (transfer && pend_flag_q) ? pend_val_q : snap_q;
  end

  // Output decode from next state so the outputs register on the transition edge.
  always_comb begin
    seg_d = SegOff;
    dp_d  = 1'b1;
    an_d  = 4'b1111;
    if (state_d == StScan) begin
      an_d = ~(4'b0001 << idx_d);
      case (idx_d)
        2'd0: seg_d = encode(snap_d[3:0]);
        2'd1: begin
          seg_d = encode(snap_d[7:4]);
          dp_d  = 1'b0;
        end
        2'd2: if (snap_d[11:8] != 4'd0) seg_d = encode(snap_d[11:8]);
        default: if (snap_d[12]) seg_d = SegMinus;
      endcase
    end
  end

  // State, counters, snapshot pipeline and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StBlank;
      idx_q       <= 2'd3;
      slot_q      <= '0;
      hold_q      <= '0;
      pend_val_q  <= '0;
      pend_flag_q <= 1'b0;
      snap_q      <= '0;
      seg_q       <= SegOff;
      dp_q        <= 1'b1;
      an_q        <= 4'b1111;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      hold_q  <= hold_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      // A capture on a transfer edge wins, leaving the fresh value pending.
      if (hold_wrap) begin
        pend_val_q  <= {neg, num2, num1, num0};
        pend_flag_q <= 1'b1;
      end else if (transfer) begin
        pend_flag_q <= 1'b0;
      end
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_level_display.sv
// Bench for level_display: a time-indexed reference model of the scan frame
// and the snapshot/transfer rules, checked every cycle, plus literal anchors.
module tb_level_display;

  localparam int S = 4;
  localparam int B = 1;
  localparam int H = 64;
  localparam int P = 4 * (S + B);

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] num2 = 4'd0, num1 = 4'd0, num0 = 4'd0;
  logic       neg = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  always #5 clk = ~clk;

  level_display #(
    .SCAN_CYCLES (S),
    .BLANK_CYCLES(B),
    .HOLD_CYCLES (H)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .num2   (num2),
    .num1   (num1),
    .num0   (num0),
    .neg    (neg),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  // Model: t = rising edges since reset release; snapshot {neg,n2,n1,n0}.
  int          t;
  logic [12:0] m_pend, m_snap;
  bit          m_pflag;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'd0: font = 7'b1000000;
      4'd1: font = 7'b1111001;
      4'd2: font = 7'b0100100;
      4'd3: font = 7'b0110000;
      4'd4: font = 7'b0011001;
      4'd5: font = 7'b0010010;
      4'd6: font = 7'b0000010;
      4'd7: font = 7'b1111000;
      4'd8: font = 7'b0000000;
      4'd9: font = 7'b0010000;
      default: font = 7'b0000110;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t       = 0;
      m_pend  = '0;
      m_snap  = '0;
      m_pflag = 1'b0;
    end else begin
      t = t + 1;
      // Transfer sees the pending value from before this edge's capture.
      if (t >= B && (t - B) % P == 0 && m_pflag) begin
        m_snap  = m_pend;
        m_pflag = 1'b0;
      end
      if (t % H == 0) begin
        m_pend  = {neg, num2, num1, num0};
        m_pflag = 1'b1;
      end
    end
  end

  // Expected {an, dp, seg} from the slot position inside the frame.
  function automatic logic [11:0] expected();
    logic [6:0] es;
    logic       ed;
    logic [3:0] ea;
    int         u, p, d;
    es = 7'b1111111;
    ed = 1'b1;
    ea = 4'b1111;
    if (reset_n && t >= B) begin
      u = t - B;
      p = u % (S + B);
      d = (u / (S + B)) % 4;
      if (p < S) begin
        ea[d] = 1'b0;
        if (d == 0) es = font(m_snap[3:0]);
        else if (d == 1) begin
          es = font(m_snap[7:4]);
          ed = 1'b0;
        end else if (d == 2) begin
          if (m_snap[11:8] != 4'd0) es = font(m_snap[11:8]);
        end else if (m_snap[12]) es = 7'b0111111;
      end
    end
    return {ea, ed, es};
  endfunction

  function automatic void check(input string name, input logic [11:0] act,
                                input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got an/dp/seg=%b/%b/%b want %b/%b/%b", name, t,
               act[11:8], act[7], act[6:0], exp[11:8], exp[7], exp[6:0]);
    end
  endfunction

  task automatic lit(input string name, input logic [3:0] ea, input logic ed,
                     input logic [6:0] es);
    check(name, {an, dp, seg}, {ea, ed, es});
  endtask

  // t advances by one per cycle, so this wait is bounded by the target.
  task automatic at_t(input int target);
    while (t < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmp_en) check("model", {an, dp, seg}, expected());
  end

  initial begin
    repeat (3) @(negedge clk);
    lit("reset_hold", 4'b1111, 1'b1, 7'b1111111);
    cmp_en  = 1'b1;
    reset_n = 1'b1;
    lit("first_blank", 4'b1111, 1'b1, 7'b1111111);
    at_t(1);   lit("d0_zero", 4'b1110, 1'b1, 7'b1000000);
    at_t(4);   lit("d0_last", 4'b1110, 1'b1, 7'b1000000);
    at_t(5);   lit("gap", 4'b1111, 1'b1, 7'b1111111);
    at_t(6);   lit("d1_zero", 4'b1101, 1'b0, 7'b1000000);
    at_t(11);  lit("d2_blank", 4'b1011, 1'b1, 7'b1111111);
    at_t(16);  lit("d3_blank", 4'b0111, 1'b1, 7'b1111111);
    // -12.5 captured at t=64, shown from the digit-0 entry at t=81.
    neg = 1'b1; num2 = 4'd1; num1 = 4'd2; num0 = 4'd5;
    at_t(81);  lit("neg_d0", 4'b1110, 1'b1, 7'b0010010);
    at_t(86);  lit("neg_d1", 4'b1101, 1'b0, 7'b0100100);
    at_t(91);  lit("neg_d2", 4'b1011, 1'b1, 7'b1111001);
    at_t(96);  lit("neg_d3", 4'b0111, 1'b1, 7'b0111111);
    // 0.7 captured at t=128 mid-frame; old frame finishes, new one at t=141.
    at_t(100);
    neg = 1'b0; num2 = 4'd0; num1 = 4'd0; num0 = 4'd7;
    at_t(131); lit("old_d2", 4'b1011, 1'b1, 7'b1111001);
    at_t(136); lit("old_d3", 4'b0111, 1'b1, 7'b0111111);
    at_t(141); lit("new_d0", 4'b1110, 1'b1, 7'b1111000);
    at_t(146); lit("new_d1", 4'b1101, 1'b0, 7'b1000000);
    at_t(151); lit("new_d2", 4'b1011, 1'b1, 7'b1111111);
    at_t(156); lit("new_d3", 4'b0111, 1'b1, 7'b1111111);
    // Non-BCD tens digit shows 'E' with the point still lit.
    num1 = 4'hC;
    at_t(201); lit("err_d0", 4'b1110, 1'b1, 7'b1111000);
    at_t(206); lit("err_d1", 4'b1101, 1'b0, 7'b0000110);
    // Asynchronous reset during the digit-2 scan slot.
    at_t(212);
    #2 reset_n = 1'b0;
    #1 lit("async_off", 4'b1111, 1'b1, 7'b1111111);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lit("rel_blank", 4'b1111, 1'b1, 7'b1111111);
    @(negedge clk);
    lit("rel_d0", 4'b1110, 1'b1, 7'b1000000);
    // Randomized inputs, including non-BCD codes and zero hundreds.
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        neg  = 1'($urandom_range(0, 1));
        num2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        num1 = 4'($urandom_range(0, 15));
        num0 = 4'($urandom_range(0, 15));
      end
    end
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_display.md
LEVEL_DISPLAY -- requirements
Module: level_display

Interface
REQ-001 Parameter SCAN_CYCLES, default 12500, is the number of clock cycles each digit is driven per scan slot (minimum 2).
REQ-002 Parameter BLANK_CYCLES, default 250, is the number of all-off anti-ghosting cycles between digits (minimum 1).
REQ-003 Parameter HOLD_CYCLES, default 6000000, is the number of clock cycles between input snapshots (minimum 4).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 num2, num1, num0  input  4 each  BCD level digits (hundreds, tens, units of tenths-of-dB); these are unsigned magnitudes.
REQ-007 neg  input  1  sign of level; 1 = negative.
REQ-008 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low.
REQ-010 an  output  4  digit enables, active-low; an[0] = rightmost digit.

Function
REQ-011 The block SHALL use a hold counter from 0 to HOLD_CYCLES-1 that wraps; on wrap it SHALL copy {neg,num2,num1,num0} into a pending register and set a pending flag.
REQ-012 Pending SHALL transfer to the displayed snapshot only on the edge entering SCAN for digit 0, then clear pending; a capture and a transfer on the same edge SHALL keep the new capture pending.
REQ-013 The FSM SHALL have two states, SCAN and BLANK, plus a 2-bit digit index and a slot counter.
REQ-014 SCAN lasts exactly SCAN_CYCLES cycles, then goes to BLANK; BLANK lasts exactly BLANK_CYCLES cycles, then goes to SCAN with the index incremented modulo 4 (3 -> 0).
REQ-015 In SCAN, exactly one an bit SHALL be low (an[index]); in BLANK, an = 4'b1111, seg = 7'b1111111 and dp = 1.
REQ-016 Outputs SHALL be registered and change on the same edge as the state/index transition that selects them; there SHALL be no combinational path from inputs to outputs.
REQ-017 Digit 0 SHALL show snapshot num0; digit 1 SHALL show num1 with dp low; digit 2 SHALL show num2, or blank if num2 = 0; digit 3 SHALL show '-' (7'b0111111) if neg = 1, otherwise blank.
REQ-018 Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 A BCD value 10-15 on any digit SHALL display 'E' (7'b0000110) in that slot.
REQ-020 Negative zero (neg = 1, all digits 0) SHALL display "-  0.0" as-is, with no sign suppression.
REQ-021 Counter widths SHALL be $clog2 of their parameter and SHALL never wrap before their terminal count.

Reset
REQ-022 While reset_n = 0, the block SHALL hold an = 4'b1111, seg = 7'b1111111, dp = 1, state = BLANK, index = 3, both counters = 0, snapshot and pending = 0, and the pending flag = 0.
REQ-023 After reset release, the first SCAN SHALL be digit 0, starting BLANK_CYCLES cycles later, and SHALL display "0.0" until the first transfer.
REQ-024 Reset asserted mid-slot or mid-hold SHALL return the block to the REQ-022 state immediately, regardless of clk.

Verification (SCAN_CYCLES=4, BLANK_CYCLES=1, HOLD_CYCLES=64)
REQ-025 Release reset, inputs 0 -> first cycle an=1111; then an=1110 for 4 cycles with seg=1000000; then 1 cycle all-off; then an=1101 with seg=1000000 and dp=0; digit 2 and digit 3 blank.
REQ-026 Apply neg=1, num=1,2,5 before the first capture -> after the next digit-0 entry, the frame shows '-', "1", "2." and "5".
REQ-027 Change the inputs mid-frame after a capture -> digits 1-3 of the current frame keep the old value; the new value appears from the next digit-0 SCAN.
REQ-028 Apply num2=0, num1=0, num0=7, neg=0 -> digits 3 and 2 are blank, digit 1 shows "0." and digit 0 shows "7".
REQ-029 Apply num1=4'hC -> digit 1 shows 7'b0000110 with dp=0; the other digits are unaffected.
REQ-030 Assert reset_n low during a digit-2 SCAN -> outputs go all-off asynchronously; after release the REQ-023 sequence repeats.
